// File: rtl/counter_load_arbiter_if.sv
// Load-request bus between the requesters and counter_load_arbiter.
// The master side is the requester pool; the slave side is the arbiter.
interface counter_load_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               wr;
    logic [DW-1:0]      wdata;
    logic               busy;
    logic [2:0]         last_id;
    logic [15:0]        load_cnt;

    modport master (
        output req, req_data,
        input  gnt, wr, wdata, busy, last_id, load_cnt
    );

    modport slave (
        input  req, req_data,
        output gnt, wr, wdata, busy, last_id, load_cnt
    );
endinterface

// File: rtl/counter_load_arbiter.sv
// counter_load_arbiter: shares a loadable counter's write port among NREQ
// requesters. One load per grant (single-cycle wr/gnt pulse), then a
// free-run gap of GAP_CYCLES cycles before the next decision.
// Build option: define COUNTER_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); the default build is round-robin.
module counter_load_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned DW         = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    counter_load_arbiter_if.slave bus
);
    localparam int unsigned IDW  = 3;
    localparam int unsigned CNTW = 16;
    localparam int unsigned GW   = 8;
    localparam int unsigned IW   = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, LOAD, GAP} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             wr_q, wr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             busy_q, busy_d;
    logic [IDW-1:0]   last_id_q, last_id_d;
    logic [CNTW-1:0]  load_cnt_q, load_cnt_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IW-1:0]    scan_idx;
    logic [DW-1:0]    win_data;

    // Winner selection; last_id doubles as the round-robin pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        win_data  = '0;
`ifdef COUNTER_ARB_FIXED_PRIO_EN
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win_found = 1'b1;
                win_idx   = IDW'(i);
            end
        end
`else
        for (int i = int'(NREQ); i >= 1; i--) begin
            scan_idx = IW'((int'(last_id_q) + i) % int'(NREQ));
            if (bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(scan_idx);
            end
        end
`endif
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win_idx == IDW'(i)) begin
                win_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        wr_d       = 1'b0;
        gnt_d      = '0;
        wdata_d    = wdata_q;
        last_id_d  = last_id_q;
        load_cnt_d = load_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = LOAD;
                    wr_d       = 1'b1;
                    gnt_d      = NREQ'(1) << win_idx;
                    wdata_d    = win_data;
                    last_id_d  = win_idx;
                    load_cnt_d = load_cnt_q + CNTW'(1);
                end
            end
            LOAD: begin
                if (GAP_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    gap_d   = GW'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            wr_q       <= 1'b0;
            gnt_q      <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            last_id_q  <= IDW'(NREQ - 1);
            load_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            wr_q       <= wr_d;
            gnt_q      <= gnt_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            last_id_q  <= last_id_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    assign bus.wr       = wr_q;
    assign bus.gnt      = gnt_q;
    assign bus.wdata    = wdata_q;
    assign bus.busy     = busy_q;
    assign bus.last_id  = last_id_q;
    assign bus.load_cnt = load_cnt_q;
endmodule

// File: tb/tb_counter_load_arbiter.sv
// Scoreboard bench for counter_load_arbiter: instance a uses GAP_CYCLES=2,
// instance b uses GAP_CYCLES=0. Stimulus pushes expected grants; monitors
// pop and compare on every wr pulse, including pulse-to-pulse spacing.
module tb_counter_load_arbiter;
    typedef struct {
        logic [3:0]  gnt;
        logic [7:0]  wdata;
        logic [2:0]  last_id;
        logic [15:0] cnt;
        int          gap;   // expected cycles since previous wr; 0 = unchecked
    } exp_t;

    logic clk = 1'b0;
    logic ra, rb;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_a = 0;
    int   last_b = 0;
    int   n;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    counter_load_arbiter_if #(.NREQ(4), .DW(8)) a_if ();
    counter_load_arbiter_if #(.NREQ(4), .DW(8)) b_if ();

    counter_load_arbiter #(.NREQ(4), .DW(8), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .reset(ra), .bus(a_if));
    counter_load_arbiter #(.NREQ(4), .DW(8), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset(rb), .bus(b_if));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for instance a.
    always @(negedge clk) begin
        if (ra) begin
            if (a_if.wr) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_wr", 32'd1, 32'd0);
                end else begin
                    ea = qa.pop_front();
                    chk("a_gnt", 32'(a_if.gnt), 32'(ea.gnt));
                    chk("a_wdata", 32'(a_if.wdata), 32'(ea.wdata));
                    chk("a_last_id", 32'(a_if.last_id), 32'(ea.last_id));
                    chk("a_load_cnt", 32'(a_if.load_cnt), 32'(ea.cnt));
                    if (ea.gap != 0) chk("a_spacing", 32'(cyc - last_a), 32'(ea.gap));
                end
                last_a = cyc;
            end else begin
                chk("a_gnt_without_wr", 32'(a_if.gnt), 32'd0);
            end
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        if (rb) begin
            if (b_if.wr) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_wr", 32'd1, 32'd0);
                end else begin
                    eb = qb.pop_front();
                    chk("b_gnt", 32'(b_if.gnt), 32'(eb.gnt));
                    chk("b_wdata", 32'(b_if.wdata), 32'(eb.wdata));
                    chk("b_last_id", 32'(b_if.last_id), 32'(eb.last_id));
                    chk("b_load_cnt", 32'(b_if.load_cnt), 32'(eb.cnt));
                    if (eb.gap != 0) chk("b_spacing", 32'(cyc - last_b), 32'(eb.gap));
                end
                last_b = cyc;
            end else begin
                chk("b_gnt_without_wr", 32'(b_if.gnt), 32'd0);
            end
        end
    end

    task automatic reset_a();
        ra = 1'b0;
        tick();
        tick();
        ra = 1'b1;
    endtask

    task automatic wait_idle_a();
        for (int k = 0; k < 20 && a_if.busy; k++) tick();
        chk("a_idle_reached", 32'(a_if.busy), 32'd0);
    endtask

    initial begin
        ra = 1'b0;
        rb = 1'b0;
        a_if.req = '0;
        a_if.req_data = '0;
        b_if.req = '0;
        b_if.req_data = '0;
        tick();
        tick();
        ra = 1'b1;
        rb = 1'b1;

        // Reset state.
        chk("rst_wr", 32'(a_if.wr), 32'd0);
        chk("rst_gnt", 32'(a_if.gnt), 32'd0);
        chk("rst_busy", 32'(a_if.busy), 32'd0);
        chk("rst_last_id", 32'(a_if.last_id), 32'd3);
        chk("rst_load_cnt", 32'(a_if.load_cnt), 32'd0);
        chk("rst_wdata", 32'(a_if.wdata), 32'd0);

        // Single request; busy for LOAD plus two GAP cycles; late data change ignored.
        a_if.req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        a_if.req = 4'b0100;
        qa.push_back('{4'b0100, 8'hA5, 3'd2, 16'd1, 0});
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_busy", 32'(a_if.busy), (k < 3) ? 32'd1 : 32'd0);
            if (k == 0) begin
                a_if.req = '0;
                a_if.req_data[23:16] = 8'hFF;
            end
        end
        chk("t2_wdata_hold", 32'(a_if.wdata), 32'hA5);

        // All four requesting: rotation from reset pointer, 4-cycle spacing.
        reset_a();
        a_if.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
`ifdef COUNTER_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 5; k++)
            qa.push_back('{4'b0001, 8'h10, 3'd0, 16'(k + 1), (k == 0) ? 0 : 4});
`else
        qa.push_back('{4'b0001, 8'h10, 3'd0, 16'd1, 0});
        qa.push_back('{4'b0010, 8'h11, 3'd1, 16'd2, 4});
        qa.push_back('{4'b0100, 8'h12, 3'd2, 16'd3, 4});
        qa.push_back('{4'b1000, 8'h13, 3'd3, 16'd4, 4});
        qa.push_back('{4'b0001, 8'h10, 3'd0, 16'd5, 4});
`endif
        a_if.req = 4'b1111;
        n = 0;
        for (int k = 0; k < 40 && n < 5; k++) begin
            tick();
            if (a_if.wr) n++;
        end
        a_if.req = '0;
        chk("t3_pulse_count", 32'(n), 32'd5);
        wait_idle_a();

        // Zero gap: two requesters alternate, pulses every 2 cycles.
        b_if.req_data = {8'h00, 8'h00, 8'hC3, 8'h3C};
`ifdef COUNTER_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++)
            qb.push_back('{4'b0001, 8'h3C, 3'd0, 16'(k + 1), (k == 0) ? 0 : 2});
`else
        qb.push_back('{4'b0001, 8'h3C, 3'd0, 16'd1, 0});
        qb.push_back('{4'b0010, 8'hC3, 3'd1, 16'd2, 2});
        qb.push_back('{4'b0001, 8'h3C, 3'd0, 16'd3, 2});
        qb.push_back('{4'b0010, 8'hC3, 3'd1, 16'd4, 2});
`endif
        b_if.req = 4'b0011;
        n = 0;
        for (int k = 0; k < 30 && n < 4; k++) begin
            tick();
            if (b_if.wr) n++;
        end
        b_if.req = '0;
        chk("t4_pulse_count", 32'(n), 32'd4);
        tick();
        tick();

        // Reset during GAP clears everything; pointer back to NREQ-1.
        a_if.req_data = {8'h00, 8'h00, 8'h66, 8'h5A};
        a_if.req = 4'b0001;
        qa.push_back('{4'b0001, 8'h5A, 3'd0, 16'd6, 0});
        tick();
        a_if.req = '0;
        tick();
        chk("t5_in_gap", 32'(a_if.busy), 32'd1);
        ra = 1'b0;
        tick();
        chk("t5_busy", 32'(a_if.busy), 32'd0);
        chk("t5_wr", 32'(a_if.wr), 32'd0);
        chk("t5_gnt", 32'(a_if.gnt), 32'd0);
        chk("t5_load_cnt", 32'(a_if.load_cnt), 32'd0);
        chk("t5_last_id", 32'(a_if.last_id), 32'd3);
        ra = 1'b1;
        a_if.req = 4'b0010;
        qa.push_back('{4'b0010, 8'h66, 3'd1, 16'd1, 0});
        n = 0;
        for (int k = 0; k < 5 && n < 1; k++) begin
            tick();
            if (a_if.wr) n++;
        end
        a_if.req = '0;
        chk("t5_regrant", 32'(n), 32'd1);
        wait_idle_a();

`ifdef COUNTER_ARB_FIXED_PRIO_EN
        // Fixed priority: req[1] always beats req[3].
        reset_a();
        a_if.req_data = {8'h99, 8'h00, 8'h77, 8'h00};
        for (int k = 0; k < 4; k++)
            qa.push_back('{4'b0010, 8'h77, 3'd1, 16'(k + 1), (k == 0) ? 0 : 4});
        a_if.req = 4'b1010;
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            tick();
            if (a_if.wr) n++;
        end
        a_if.req = '0;
        chk("t6_pulse_count", 32'(n), 32'd4);
        wait_idle_a();
`endif

        tick();
        tick();
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
